// File: rtl/sprite_ctrl.sv
// sprite_ctrl: per-frame erase / move / redraw sequencer for a square sprite.
// Each frame_tick erases the sprite at its old position (skipped until the
// first draw has happened), applies one step of motion, then draws it at the
// new position, one pixel per cycle.
// Build option: define SPRITE_CTRL_WRAP_EN to make the sprite wrap around the
// screen edges instead of stopping at them.
//
// Handshake: frame_tick is a fire-and-forget pulse with no ready. busy=1 means
// the sequencer is inside a pass; a tick seen while busy is remembered (at
// most one) and starts the next pass as soon as the current one finishes.
module sprite_ctrl #(
   parameter int X_MAX  = 160,
   parameter int Y_MAX  = 120,
   parameter int SIZE   = 16,
   parameter int X_INIT = 72,
   parameter int Y_INIT = 52
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic       left,
   input  logic       right,
   input  logic       up,
   input  logic       down,
   input  logic [5:0] color_sel,
   output logic [7:0] x0,
   output logic [6:0] y0,
   output logic       undraw,
   output logic [5:0] color_out,
   output logic       plot,
   output logic       busy
);

   // Largest legal top-left coordinates and the last pixel index of a pass.
   localparam logic [7:0] X_LIM    = 8'(X_MAX - SIZE);
   localparam logic [6:0] Y_LIM    = 7'(Y_MAX - SIZE);
   localparam logic [7:0] CNT_LAST = 8'(SIZE * SIZE - 1);
   localparam logic [7:0] X_RST    = 8'(X_INIT);
   localparam logic [6:0] Y_RST    = 7'(Y_INIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ERASE  = 2'd1,
      UPDATE = 2'd2,
      DRAW   = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  x0_q, x_d;
   logic [6:0]  y0_q, y_d;
   logic [5:0]  color_q;
   logic        plot_q, undraw_q, busy_q;
   logic        pending_q, drawn_q;

   // Next position: one step per axis, opposing requests cancel; at an edge
   // the step is either discarded or wrapped to the opposite edge.
   always_comb begin
      x_d = x0_q;
      y_d = y0_q;
      if (right && !left) begin
         if (x0_q < X_LIM) x_d = x0_q + 8'd1;
`ifdef SPRITE_CTRL_WRAP_EN
         else x_d = 8'd0;
`endif
      end else if (left && !right) begin
         if (x0_q > 8'd0) x_d = x0_q - 8'd1;
`ifdef SPRITE_CTRL_WRAP_EN
         else x_d = X_LIM;
`endif
      end
      if (down && !up) begin
         if (y0_q < Y_LIM) y_d = y0_q + 7'd1;
`ifdef SPRITE_CTRL_WRAP_EN
         else y_d = 7'd0;
`endif
      end else if (up && !down) begin
         if (y0_q > 7'd0) y_d = y0_q - 7'd1;
`ifdef SPRITE_CTRL_WRAP_EN
         else y_d = Y_LIM;
`endif
      end
   end

   // Pass sequencer with registered plot/undraw/busy and the one-deep tick queue.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         x0_q      <= X_RST;
         y0_q      <= Y_RST;
         color_q   <= 6'd0;
         plot_q    <= 1'b0;
         undraw_q  <= 1'b0;
         busy_q    <= 1'b0;
         pending_q <= 1'b0;
         drawn_q   <= 1'b0;
      end else begin
         // A tick during a pass (including its last cycle) is queued.
         if (frame_tick && busy_q) pending_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (frame_tick || pending_q) begin
                  pending_q <= 1'b0;
                  cnt_q     <= 8'd0;
                  busy_q    <= 1'b1;
                  if (drawn_q) begin
                     state_q  <= ERASE;
                     plot_q   <= 1'b1;
                     undraw_q <= 1'b1;
                  end else begin
                     state_q  <= UPDATE;
                     plot_q   <= 1'b0;
                     undraw_q <= 1'b0;
                  end
               end
            end
            ERASE: begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == CNT_LAST) begin
                  state_q  <= UPDATE;
                  cnt_q    <= 8'd0;
                  plot_q   <= 1'b0;
                  undraw_q <= 1'b0;
               end
            end
            UPDATE: begin
               x0_q     <= x_d;
               y0_q     <= y_d;
               color_q  <= color_sel;
               cnt_q    <= 8'd0;
               state_q  <= DRAW;
               plot_q   <= 1'b1;
               undraw_q <= 1'b0;
            end
            DRAW: begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= 8'd0;
                  plot_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  drawn_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               plot_q   <= 1'b0;
               undraw_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign x0        = x0_q;
   assign y0        = y0_q;
   assign undraw    = undraw_q;
   assign color_out = color_q;
   assign plot      = plot_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sprite_ctrl.sv
// tb_sprite_ctrl: directed bench for sprite_ctrl. A frame-level model derives
// the expected outputs of every cycle from pass start times; literal checks
// pin the key timings and positions. Honours SPRITE_CTRL_WRAP_EN.
module tb_sprite_ctrl;

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       resetn = 1'b1;
   logic       frame_tick = 1'b0;
   logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
   logic [5:0] color_sel = 6'd0;
   logic [7:0] x0;
   logic [6:0] y0;
   logic       undraw, plot, busy;
   logic [5:0] color_out;

   always #5 clock = ~clock;

   sprite_ctrl dut (
      .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
      .left(left), .right(right), .up(up), .down(down),
      .color_sel(color_sel), .x0(x0), .y0(y0), .undraw(undraw),
      .color_out(color_out), .plot(plot), .busy(busy)
   );

`ifdef SPRITE_CTRL_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // ---------------- frame-level model ----------------
   int         cyc = 0;
   bit         m_active, m_pend, m_drawn, m_erase;
   int         m_start, m_end, m_upd;
   int         m_x, m_y;
   logic [5:0] m_col;
   int         m_c, m_k, m_dx, m_dy;
   bit         m_busy_c;
   logic       e_busy, e_plot, e_undraw;

   function automatic int step(input int p, input int d, input int lim);
      int n;
      n = p + d;
      if (WRAP) begin
         if (n < 0) n = lim;
         else if (n > lim) n = 0;
      end else if (n < 0 || n > lim) begin
         n = p;
      end
      return n;
   endfunction

   // Model: a pass started by a tick in cycle s is busy for s+1..s+end-1;
   // with an erase the update cycle is s+257 (end 514), otherwise s+1 (end 258).
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_active = 0; m_pend = 0; m_drawn = 0; m_erase = 0;
         m_x = 72; m_y = 52; m_col = 6'd0;
         e_busy = 0; e_plot = 0; e_undraw = 0;
      end else begin
         m_c = cyc;
         m_busy_c = m_active && (m_c > m_start) && (m_c < m_start + m_end);
         if (m_active && m_c >= m_start + m_end) m_active = 0;
         if (m_busy_c && frame_tick) m_pend = 1;
         if (m_busy_c && m_c == m_start + m_upd) begin
            m_dx = int'(right) - int'(left);
            m_dy = int'(down) - int'(up);
            m_x = step(m_x, m_dx, 144);
            m_y = step(m_y, m_dy, 104);
            m_col = color_sel;
         end
         if (m_busy_c && m_c == m_start + m_end - 1) m_drawn = 1;
         if (!m_busy_c && (frame_tick || m_pend)) begin
            m_active = 1; m_start = m_c; m_erase = m_drawn; m_pend = 0;
            m_upd = m_erase ? 257 : 1;
            m_end = m_erase ? 514 : 258;
         end
         m_k = m_c + 1 - m_start;
         e_busy   = m_active && m_k >= 1 && m_k < m_end;
         e_plot   = e_busy && m_k != m_upd;
         e_undraw = e_busy && m_erase && m_k < m_upd;
         cyc = m_c + 1;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clock) begin
      if (chk_en) begin
         checks++;
         if (busy !== e_busy || plot !== e_plot || undraw !== e_undraw ||
             int'(x0) != m_x || int'(y0) != m_y || color_out !== m_col ||
             $isunknown({x0, y0, color_out})) begin
            errors++;
            $display("FAIL cycle_cmp cyc=%0d got busy=%b plot=%b undraw=%b x0=%0d y0=%0d col=%h exp busy=%b plot=%b undraw=%b x0=%0d y0=%0d col=%h",
                     cyc, busy, plot, undraw, x0, y0, color_out,
                     e_busy, e_plot, e_undraw, m_x, m_y, m_col);
         end
      end
   end

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_tick();
      @(negedge clock); frame_tick = 1'b1;
      @(negedge clock); frame_tick = 1'b0;
   endtask

   // Called at cycle t+1 after a tick in cycle t; len is the first idle offset.
   task automatic measure_pass(output int len, output int nplot, output int nund,
                               output int ux, output int uy);
      len = -1; nplot = 0; nund = 0; ux = -1; uy = -1;
      for (int i = 1; i <= 1200; i++) begin
         if (!busy) begin len = i; break; end
         if (plot) nplot++;
         if (undraw) begin
            nund++;
            if (nund == 1) begin ux = int'(x0); uy = int'(y0); end
         end
         @(negedge clock);
      end
   endtask

   task automatic set_dirs(input logic l, input logic r, input logic u, input logic d);
      @(negedge clock);
      left = l; right = r; up = u; down = d;
   endtask

   // ---------------- stimulus ----------------
   int len, np, nu, ux, uy;
   int rises, fall_at, rise2;
   logic prev;

   initial begin
      #1 resetn = 1'b0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      chk_en = 1'b1;

      // Reset state
      check_int("rst_x0", int'(x0), 72);
      check_int("rst_y0", int'(y0), 52);
      check_int("rst_busy", int'(busy), 0);
      check_int("rst_plot", int'(plot), 0);
      check_int("rst_undraw", int'(undraw), 0);
      check_int("rst_color", int'(color_out), 0);

      // First frame: no erase, move right, latch colour
      set_dirs(0, 1, 0, 0); color_sel = 6'h30;
      send_tick();
      measure_pass(len, np, nu, ux, uy);
      check_int("p1_len", len, 258);
      check_int("p1_plot", np, 256);
      check_int("p1_undraw", nu, 0);
      check_int("p1_x0", int'(x0), 73);
      check_int("p1_y0", int'(y0), 52);
      check_int("p1_color", int'(color_out), 'h30);

      // Second frame: erase at old spot, move down
      set_dirs(0, 0, 0, 1); color_sel = 6'h0A;
      send_tick();
      measure_pass(len, np, nu, ux, uy);
      check_int("p2_len", len, 514);
      check_int("p2_plot", np, 512);
      check_int("p2_undraw", nu, 256);
      check_int("p2_erase_x", ux, 73);
      check_int("p2_erase_y", uy, 52);
      check_int("p2_x0", int'(x0), 73);
      check_int("p2_y0", int'(y0), 53);
      check_int("p2_color", int'(color_out), 'h0A);

      // Drive to the top-right corner: 53 frames right+up -> (126,0)
      set_dirs(0, 1, 1, 0);
      for (int f = 0; f < 53; f++) begin
         send_tick();
         measure_pass(len, np, nu, ux, uy);
      end
      check_int("corner_y0", int'(y0), 0);
      check_int("corner_x0", int'(x0), 126);
      // y at the top edge: clamp stays 0, wrap goes to 104
      send_tick();
      measure_pass(len, np, nu, ux, uy);
      check_int("edge_y0", int'(y0), WRAP ? 104 : 0);
      // 17 frames right only -> x 144
      set_dirs(0, 1, 0, 0);
      for (int f = 0; f < 17; f++) begin
         send_tick();
         measure_pass(len, np, nu, ux, uy);
      end
      check_int("edge_x0_reach", int'(x0), 144);
      // x at right edge: clamp stays 144, wrap goes to 0
      send_tick();
      measure_pass(len, np, nu, ux, uy);
      check_int("edge_x0", int'(x0), WRAP ? 0 : 144);

      // Three ticks in one pass, opposing requests on both axes
      set_dirs(1, 1, 1, 1);
      send_tick();
      rises = 0; fall_at = -1; rise2 = -1; prev = 1'b0;
      for (int i = 1; i <= 1600; i++) begin
         frame_tick = (i == 20 || i == 40 || i == 60);
         if (busy && !prev) begin
            rises++;
            if (fall_at >= 0 && rise2 < 0) rise2 = i;
         end
         if (!busy && prev && fall_at < 0) fall_at = i;
         prev = busy;
         @(negedge clock);
      end
      frame_tick = 1'b0;
      check_int("queued_passes", rises, 2);
      check_int("queued_fall", fall_at, 514);
      check_int("queued_rise", rise2, 515);
      check_int("hold_x0", int'(x0), WRAP ? 0 : 144);
      check_int("hold_y0", int'(y0), WRAP ? 104 : 0);

      // Tick in the last DRAW cycle is queued: one idle cycle then a new pass
      set_dirs(0, 0, 0, 0);
      send_tick();                           // now at cycle t+1
      repeat (512) @(negedge clock);         // cycle t+513
      frame_tick = 1'b1;
      @(negedge clock); frame_tick = 1'b0;   // cycle t+514
      check_int("edge_tick_idle", int'(busy), 0);
      @(negedge clock);                      // cycle t+515
      check_int("edge_tick_restart", int'(busy), 1);
      check_int("edge_tick_undraw", int'(undraw), 1);
      measure_pass(len, np, nu, ux, uy);

      // Reset during DRAW pixel 100 (offset 358 after the tick)
      send_tick();
      repeat (357) @(negedge clock);
      check_int("pre_rst_draw", int'(plot && !undraw), 1);
      #2 resetn = 1'b0;
      #1;
      check_int("async_plot", int'(plot), 0);
      check_int("async_busy", int'(busy), 0);
      check_int("async_x0", int'(x0), 72);
      check_int("async_y0", int'(y0), 52);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      send_tick();
      check_int("post_rst_update_busy", int'(busy), 1);
      check_int("post_rst_update_plot", int'(plot), 0);
      measure_pass(len, np, nu, ux, uy);
      check_int("post_rst_len", len, 258);
      check_int("post_rst_undraw", nu, 0);

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the whole run is far shorter than this.
   initial begin
      #1500000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1);
   end

endmodule
